// File: rtl/aes_128_sched_pkg.sv
// Shared defaults and types for the two-requester AES-128 front-end scheduler.
package aes_128_sched_pkg;

    localparam int CORE_LAT_DEF   = 21;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic [127:0] data;
        req_id_t      id;
    } result_t;

endpackage

// File: rtl/aes_128_sched_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero while empty.
module aes_128_sched_fifo
    import aes_128_sched_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  result_t       push_data_i,
    input  logic          pop_i,
    output result_t       head_o,
    output logic [CW-1:0] count_o
);

    result_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (count_q != CW'(DEPTH));

    // Pointers are PW bits wide, so they wrap modulo the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/aes_128_sched.sv
// Round-robin, credit-based scheduler feeding a free-running AES-128 core and
// returning ciphertexts in acceptance order through a result FIFO.
module aes_128_sched
    import aes_128_sched_pkg::*;
#(
    parameter int CORE_LAT   = CORE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_state,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_state,
    input  logic [127:0] req1_key,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                ptr_q, ptr_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       fifo_count;
    logic [CORE_LAT-1:0] sr_vld_q, sr_vld_d;
    logic [CORE_LAT-1:0] sr_id_q, sr_id_d;
    logic [127:0]        core_state_q, core_state_d;
    logic [127:0]        core_key_q, core_key_d;
    logic                credit;
    logic                grant0, grant1, accept;
    req_id_t             grant_id;
    logic                retire;
    result_t             push_data;
    result_t             head;

    // Credit counts results already in the core plus those buffered; a pop on
    // this edge is deliberately not credited until the next cycle.
    assign credit   = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign grant0   = !rst && credit && req0_valid && (!ptr_q || !req1_valid);
    assign grant1   = !rst && credit && req1_valid && (ptr_q || !req0_valid);
    assign accept   = grant0 || grant1;
    assign grant_id = grant1;
    assign retire   = sr_vld_q[CORE_LAT-1];

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        ptr_d        = ptr_q;
        inflight_d   = inflight_q;
        sr_vld_d     = {sr_vld_q[CORE_LAT-2:0], accept};
        sr_id_d      = {sr_id_q[CORE_LAT-2:0], grant_id};
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (accept) begin
            ptr_d        = ~grant_id;
            core_state_d = grant1 ? req1_state : req0_state;
            core_key_d   = grant1 ? req1_key   : req0_key;
        end
        if (accept && !retire)      inflight_d = inflight_q + 1'b1;
        else if (!accept && retire) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            inflight_q   <= '0;
            sr_vld_q     <= '0;
            sr_id_q      <= '0;
            core_state_q <= '0;
            core_key_q   <= '0;
        end else begin
            ptr_q        <= ptr_d;
            inflight_q   <= inflight_d;
            sr_vld_q     <= sr_vld_d;
            sr_id_q      <= sr_id_d;
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
        end
    end

    assign push_data.data = core_out;
    assign push_data.id   = sr_id_q[CORE_LAT-1];

    aes_128_sched_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (retire),
        .push_data_i(push_data),
        .pop_i      (rsp_ready),
        .head_o     (head),
        .count_o    (fifo_count)
    );

    assign core_state = core_state_q;
    assign core_key   = core_key_q;
    assign rsp_valid  = (fifo_count != '0);
    assign rsp_data   = head.data;
    assign rsp_id     = head.id;
    assign busy       = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed bench for aes_128_sched with a latency-matched stand-in for the AES core.
module tb_aes_128_sched;

    localparam int CL = 21;
    localparam int FD = 8;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_state, req1_state, req0_key, req1_key;
    logic [127:0] core_state, core_key, core_out;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [127:0] rsp_data;

    typedef struct packed {
        logic [127:0] d;
        logic         id;
    } exp_t;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    logic         acc0, acc1;
    logic [127:0] pipe [CL-1];

    aes_128_sched #(.CORE_LAT(CL), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_state(req0_state),
        .req0_key  (req0_key),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_state(req1_state),
        .req1_key  (req1_key),
        .core_state(core_state),
        .core_key  (core_key),
        .core_out  (core_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in core: the FIPS-197 vector maps to its known ciphertext, anything
    // else to a distinct mix; input registered at edge T is consumed at T+CL.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        if (s == PT && k == KEY) return CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_ffff_1234_a5a5_4321_0f0f_c3c3;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= core_f(core_state, core_key);
        for (int i = 1; i < CL - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[CL-2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, score pops, record accepts.
    task automatic tick();
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (acc0 && acc1) chk("single_grant", 128'd1, 128'd0);
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("pop_unexpected", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_id", 128'(rsp_id), 128'(e.id));
            end
        end
        if (acc0) q.push_back({core_f(req0_state, req0_key), 1'b0});
        if (acc1) q.push_back({core_f(req1_state, req1_key), 1'b1});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 128'(q.size()), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int cnt;
        logic [127:0] held;
        logic flag;

        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_state = '0;
        req1_state = '0;
        req0_key   = '0;
        req1_key   = '0;
        rsp_ready  = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        chk("rst_rsp_id", 128'(rsp_id), 128'd0);
        chk("rst_core_state", core_state, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_req0_ready", 128'(req0_ready), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;

        // Known-answer vector and minimum latency
        req0_state = PT;
        req0_key   = KEY;
        req0_valid = 1'b1;
        tick();
        chk("kat_accept", 128'(acc0), 128'd1);
        req0_valid = 1'b0;
        chk("kat_core_state", core_state, PT);
        chk("kat_core_key", core_key, KEY);
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        chk("kat_latency", 128'(n), 128'd21);
        chk("kat_rsp_data", rsp_data, CT);
        chk("kat_rsp_id", 128'(rsp_id), 128'd0);
        held = rsp_data;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (rsp_data !== held || rsp_valid !== 1'b1) flag = 1'b1;
        end
        chk("stall_stable", 128'(flag), 128'd0);
        rsp_ready = 1'b1;
        tick();
        chk("kat_popped_valid", 128'(rsp_valid), 128'd0);
        chk("kat_idle_busy", 128'(busy), 128'd0);
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (rsp_data !== 128'd0 || rsp_valid !== 1'b0) flag = 1'b1;
        end
        chk("empty_pop_no_effect", 128'(flag), 128'd0);

        // Round-robin with both requesters valid
        do_reset();
        rsp_ready  = 1'b1;
        req0_key   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req1_key   = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
        req0_state = 128'h0000_0000_0000_0000_0000_0000_0000_0100;
        req1_state = 128'h0000_0000_0000_0000_0000_0000_0000_0200;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_grant0", 128'(acc0), 128'((i % 2) == 0));
            chk("rr_grant1", 128'(acc1), 128'((i % 2) == 1));
            if (acc0) req0_state = req0_state + 128'd1;
            if (acc1) req1_state = req1_state + 128'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("rr_drain");

        // Credit limit with a stalled consumer
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        cnt = 0;
        repeat (40) begin
            tick();
            if (acc0) begin
                cnt++;
                req0_state = req0_state + 128'd1;
            end
        end
        chk("credit_accepts", 128'(cnt), 128'd8);
        chk("credit_ready_low", 128'(req0_ready), 128'd0);
        chk("credit_rsp_valid", 128'(rsp_valid), 128'd1);
        rsp_ready = 1'b1;
        tick();
        chk("pop_no_same_cycle_credit", 128'(acc0), 128'd0);
        rsp_ready = 1'b0;
        cnt = 0;
        repeat (30) begin
            tick();
            if (acc0) begin
                cnt++;
                req0_state = req0_state + 128'd1;
            end
        end
        chk("one_pop_one_accept", 128'(cnt), 128'd1);

        // Streaming while full by credit: simultaneous accept and pop
        rsp_ready = 1'b1;
        flag = 1'b0;
        cnt = 0;
        repeat (60) begin
            tick();
            if (acc0) begin
                cnt++;
                req0_state = req0_state + 128'd1;
            end
            if (q.size() > FD) flag = 1'b1;
        end
        chk("stream_credit_bound", 128'(flag), 128'd0);
        chk("stream_progress", 128'(cnt > 8), 128'd1);
        req0_valid = 1'b0;
        drain("stream_drain");
        chk("stream_idle_busy", 128'(busy), 128'd0);

        // Reset mid-operation discards everything
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        cnt = 0;
        repeat (3) begin
            tick();
            if (acc0) cnt++;
            req0_state = req0_state + 128'd1;
        end
        chk("pre_reset_accepts", 128'(cnt), 128'd3);
        req0_valid = 1'b0;
        repeat (5) tick();
        chk("pre_reset_busy", 128'(busy), 128'd1);
        req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("midrst_req0_ready", 128'(req0_ready), 128'd0);
        chk("midrst_core_state", core_state, 128'd0);
        q.delete();
        req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        flag = 1'b0;
        repeat (30) begin
            tick();
            if (rsp_valid || busy) flag = 1'b1;
        end
        chk("midrst_no_stale", 128'(flag), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
